// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: state encoding,
// MEMControl bit positions, abort data and the captured-request record.
package cpu_mem_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_IF_BUSY  = 2'd1;
  localparam logic [1:0] ST_MEM_BUSY = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  localparam int MEM_RD = 1;
  localparam int MEM_WR = 0;

  localparam logic [31:0] ABORT_DATA = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } mem_req_t;

  // A set write bit wins, so 2'b11 behaves as a store.
  function automatic logic is_write(input logic [1:0] ctl);
    return ctl[MEM_WR];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave = arbiter view, master = CPU/memory environment view.
interface mem_port_arbiter_if;

  logic        IFReq;
  logic [31:0] IFAddr;
  logic        IFReady;
  logic [31:0] IFData;
  logic [1:0]  MEMControl;
  logic [31:0] MEMAddress;
  logic [31:0] MEMData;
  logic        MEMReady;
  logic [31:0] MEMRdData;
  logic        MemEn;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;
  logic        StallIF;
  logic        StallPipe;
  logic        BusErr;

  modport slave (
    input  IFReq, IFAddr, MEMControl, MEMAddress, MEMData, MemRData, MemAck,
    output IFReady, IFData, MEMReady, MEMRdData, MemEn, MemWe, MemAddr, MemWData,
           StallIF, StallPipe, BusErr
  );

  modport master (
    output IFReq, IFAddr, MEMControl, MEMAddress, MEMData, MemRData, MemAck,
    input  IFReady, IFData, MEMReady, MEMRdData, MemEn, MemWe, MemAddr, MemWData,
           StallIF, StallPipe, BusErr
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Counts BUSY cycles without an ack; o_expired flags the cycle whose
// edge would reach TIMEOUT, so the abort lands exactly on that edge.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  import cpu_mem_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Saturating wait counter, cleared when a new access is granted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_en && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the fetch and memory
// stages, holding each access until MemAck or a timeout abort.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT       = 16,
  parameter int MAX_MEM_BURST = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int BW = $clog2(MAX_MEM_BURST + 1);

  logic [1:0]    r_state;
  mem_req_t      r_req;
  logic          r_mem_en;
  logic          r_if_ready;
  logic          r_mem_ready;
  logic [31:0]   r_if_data;
  logic [31:0]   r_mem_rdata;
  logic          r_bus_err;
  logic [BW-1:0] r_burst;

  logic     w_mem_req;
  logic     w_burst_full;
  logic     w_idle;
  logic     w_busy;
  logic     w_grant_mem;
  logic     w_grant_if;
  logic     w_tmo_en;
  logic     w_expired;
  logic     w_ack;
  logic     w_abort;
  mem_req_t w_req;

  assign w_mem_req    = (bus.MEMControl != 2'b00);
  assign w_burst_full = (r_burst == BW'(MAX_MEM_BURST));
  assign w_idle       = (r_state == ST_IDLE);
  assign w_busy       = (r_state == ST_IF_BUSY) || (r_state == ST_MEM_BUSY);
  assign w_tmo_en     = w_busy && !bus.MemAck;
  assign w_ack        = w_busy && bus.MemAck;
  assign w_abort      = w_tmo_en && w_expired;

  // Grant selection: MEM first unless it has starved a waiting fetch.
  always_comb begin
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_req       = r_req;
    if (w_idle && w_mem_req && !(w_burst_full && bus.IFReq)) begin
      w_grant_mem = 1'b1;
      w_req.addr  = bus.MEMAddress;
      w_req.wdata = bus.MEMData;
      w_req.we    = is_write(bus.MEMControl);
    end else if (w_idle && bus.IFReq) begin
      w_grant_if  = 1'b1;
      w_req.addr  = bus.IFAddr;
      w_req.wdata = r_req.wdata;
      w_req.we    = 1'b0;
    end else begin
      w_req = r_req;
    end
  end

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (Clk),
    .i_rst     (Rst),
    .i_clr     (w_grant_mem || w_grant_if),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  // Access FSM: capture on grant, complete on ack or abort, one RESP cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_mem_en    <= 1'b0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_if_data   <= 32'h0000_0000;
      r_mem_rdata <= 32'h0000_0000;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_mem || w_grant_if) begin
            r_req    <= w_req;
            r_mem_en <= 1'b1;
          end
          if (w_grant_mem) begin
            r_state <= ST_MEM_BUSY;
          end else if (w_grant_if) begin
            r_state <= ST_IF_BUSY;
          end
        end
        ST_IF_BUSY, ST_MEM_BUSY: begin
          if (w_ack || w_abort) begin
            r_state  <= ST_RESP;
            r_mem_en <= 1'b0;
            r_req.we <= 1'b0;
            if (r_state == ST_IF_BUSY) begin
              r_if_ready <= 1'b1;
              r_if_data  <= w_ack ? bus.MemRData : ABORT_DATA;
            end else begin
              r_mem_ready <= 1'b1;
              // Stores return nothing; the load data register keeps its value.
              if (!r_req.we) begin
                r_mem_rdata <= w_ack ? bus.MemRData : ABORT_DATA;
              end
            end
          end
          if (w_abort) begin
            r_bus_err <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Consecutive MEM grants taken while a fetch waits.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_burst <= '0;
    end else if (!bus.IFReq || w_grant_if) begin
      r_burst <= '0;
    end else if (w_grant_mem && !w_burst_full) begin
      r_burst <= r_burst + BW'(1);
    end
  end

  assign bus.IFReady   = r_if_ready;
  assign bus.IFData    = r_if_data;
  assign bus.MEMReady  = r_mem_ready;
  assign bus.MEMRdData = r_mem_rdata;
  assign bus.MemEn     = r_mem_en;
  assign bus.MemWe     = r_req.we;
  assign bus.MemAddr   = r_req.addr;
  assign bus.MemWData  = r_req.wdata;
  assign bus.BusErr    = r_bus_err;
  assign bus.StallIF   = bus.IFReq && !r_if_ready;
  assign bus.StallPipe = w_mem_req && !r_mem_ready;

endmodule
